alu_issue_ctrl: RTL and testbench

- Issue/control front end that produces opcodes for the lab2 ALU. It sits on the opposite side of the ALU opcode interface from the ALU itself.
- Accepts 9-bit instruction words over a valid/ready handshake and decodes them into the team's 4-bit ALU opcode map (doNothing 0x0 through adduTwo 0xD).
- Sequences each operation: start pulse, wait for ALU done, then writeback pulse.
- Tracks retired-instruction count, halt, illegal-opcode and ALU-timeout conditions.

---
 rtl/alu_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issue/control front end for the lab2 ALU. Accepts 9-bit instruction words
// over a valid/ready handshake, decodes the 4-bit opcode, launches ALU
// operations with a start pulse, waits for done and produces a one-cycle
// register-file writeback strobe. It also tracks the retired-instruction
// count, the HALT state, and sticky illegal-opcode and ALU-timeout flags.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     instruction word present
//   in_ready     controller can accept an instruction (IDLE only)
//   in_instr     [8:5] opcode, [4:2] rd, [1:0] rs
//   alu_op       opcode to ALU, held until the next ALU op is accepted
//   alu_rd       destination field, held with alu_op
//   alu_rs       source field, held with alu_op
//   alu_start    one-cycle pulse launching the ALU op
//   alu_done     ALU result valid (sampled in WAIT only)
//   wb_en        one-cycle register-file write strobe
//   wb_addr      write destination (0 outside the writeback cycle)
//   halted       controller stopped by HALT until reset
//   illegal      sticky: opcode 0xF was received
//   timeout_err  sticky: ALU failed to respond within TIMEOUT WAIT cycles
//   retired      retired-instruction count, wraps modulo 2^CNT_W
module alu_issue_ctrl #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_instr,
    output logic [3:0]       alu_op,
    output logic [2:0]       alu_rd,
    output logic [1:0]       alu_rs,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             wb_en,
    output logic [2:0]       wb_addr,
    output logic             halted,
    output logic             illegal,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_HALT    = 4'hE;
    localparam logic [3:0] OP_ILLEGAL = 4'hF;

    // Index of the last WAIT cycle before the op is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           stateQ, stateD;
    logic [7:0]       waitCnt;
    logic [3:0]       opQ;
    logic [2:0]       rdQ;
    logic [1:0]       rsQ;
    logic             illegalQ;
    logic             timeoutQ;
    logic [CNT_W-1:0] retiredQ;

    logic [3:0] inOpcode;
    logic       accept;
    logic       acceptAluOp;
    logic       retireNow;
    logic       timeoutHit;

    assign inOpcode    = in_instr[8:5];
    assign accept      = in_valid && (stateQ == IDLE);
    assign acceptAluOp = accept && (inOpcode != OP_NOP) && (inOpcode != OP_HALT)
                         && (inOpcode != OP_ILLEGAL);
    // doNothing retires straight from IDLE; ALU ops retire in their WB cycle.
    assign retireNow   = (accept && (inOpcode == OP_NOP)) || (stateQ == WB);
    assign timeoutHit  = (stateQ == WAIT) && !alu_done && (waitCnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        in_ready  = 1'b0;
        alu_start = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = 3'd0;
        halted    = 1'b0;
        case (stateQ)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (inOpcode)
                        OP_HALT:            stateD = HALT;
                        OP_NOP, OP_ILLEGAL: stateD = IDLE;
                        default:            stateD = START;
                    endcase
                end
            end
            START: begin
                alu_start = 1'b1;
                stateD    = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    stateD = WB;
                end else if (waitCnt == WAIT_LAST) begin
                    stateD = IDLE;
                end
            end
            WB: begin
                wb_en   = 1'b1;
                wb_addr = rdQ;
                stateD  = IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt  <= 8'd0;
            opQ      <= 4'h0;
            rdQ      <= 3'd0;
            rsQ      <= 2'd0;
            illegalQ <= 1'b0;
            timeoutQ <= 1'b0;
            retiredQ <= '0;
        end else begin
            // Counts WAIT cycles; cleared whenever the FSM is elsewhere.
            if (stateQ == WAIT) begin
                waitCnt <= waitCnt + 8'd1;
            end else begin
                waitCnt <= 8'd0;
            end
            if (acceptAluOp) begin
                opQ <= inOpcode;
                rdQ <= in_instr[4:2];
                rsQ <= in_instr[1:0];
            end
            if (accept && (inOpcode == OP_ILLEGAL)) begin
                illegalQ <= 1'b1;
            end
            if (timeoutHit) begin
                timeoutQ <= 1'b1;
            end
            if (retireNow) begin
                retiredQ <= retiredQ + CNT_W'(1);
            end
        end
    end

    assign alu_op      = opQ;
    assign alu_rd      = rdQ;
    assign alu_rs      = rsQ;
    assign illegal     = illegalQ;
    assign timeout_err = timeoutQ;
    assign retired     = retiredQ;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: directed scenarios followed by randomized
// instruction traffic, checked against a transaction-level model that
// predicts handshake timing, pulses, flags and the retired count.
module tb_alu_issue_ctrl;

    localparam int TIMEOUT = 32;
    localparam int CNT_W   = 5;
    localparam int NEVER   = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [8:0]       in_instr = 9'd0;
    logic [3:0]       alu_op;
    logic [2:0]       alu_rd;
    logic [1:0]       alu_rs;
    logic             alu_start;
    logic             alu_done = 1'b0;
    logic             wb_en;
    logic [2:0]       wb_addr;
    logic             halted;
    logic             illegal;
    logic             timeout_err;
    logic [CNT_W-1:0] retired;

    alu_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_op(alu_op), .alu_rd(alu_rd), .alu_rs(alu_rs),
        .alu_start(alu_start), .alu_done(alu_done), .wb_en(wb_en),
        .wb_addr(wb_addr), .halted(halted), .illegal(illegal),
        .timeout_err(timeout_err), .retired(retired)
    );

    always #5 clk = ~clk;

    // Reference model state
    int               nChecks = 0;
    int               nFails = 0;
    logic [CNT_W-1:0] expRetired = '0;
    logic             expIllegal = 1'b0;
    logic             expTimeout = 1'b0;
    logic [3:0]       expOp = 4'h0;
    logic [2:0]       expRd = 3'd0;
    logic [1:0]       expRs = 2'd0;
    int               expStarts = 0;
    int               expWbs = 0;
    int               seenStarts = 0;
    int               seenWbs = 0;

    always @(negedge clk) begin
        if (alu_start) seenStarts++;
        if (wb_en) seenWbs++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_ready"}, in_ready, 1);
        checkVal({tag, "_start"}, alu_start, 0);
        checkVal({tag, "_wb"}, wb_en, 0);
        checkVal({tag, "_wbaddr"}, wb_addr, 0);
        checkVal({tag, "_halted"}, halted, 0);
        checkVal({tag, "_illegal"}, illegal, 0);
        checkVal({tag, "_tmo"}, timeout_err, 0);
        checkVal({tag, "_retired"}, retired, 0);
        checkVal({tag, "_op"}, {alu_op, alu_rd, alu_rs}, 0);
    endtask

    task automatic modelReset();
        expRetired = '0;
        expIllegal = 1'b0;
        expTimeout = 1'b0;
        expOp = 4'h0;
        expRd = 3'd0;
        expRs = 2'd0;
    endtask

    // Present one instruction from IDLE and follow it to completion.
    // delay = WAIT cycle in which the ALU answers (>= TIMEOUT means never).
    task automatic sendInstr(input logic [3:0] op, input logic [2:0] rd,
                             input logic [1:0] rs, input int delay);
        bit gotDone = 0;
        checkVal("idle_ready", in_ready, 1);
        checkVal("idle_hold", {alu_op, alu_rd, alu_rs}, {expOp, expRd, expRs});
        in_valid = 1'b1;
        in_instr = {op, rd, rs};
        step();
        in_valid = 1'b0;
        in_instr = 9'($urandom);
        if (op == 4'h0) begin
            expRetired = expRetired + 1'b1;
            checkVal("nop_retired", retired, expRetired);
            checkVal("nop_nostart", alu_start, 0);
            checkVal("nop_ready", in_ready, 1);
        end else if (op == 4'hF) begin
            expIllegal = 1'b1;
            checkVal("ill_flag", illegal, 1);
            checkVal("ill_nostart", alu_start, 0);
            checkVal("ill_ready", in_ready, 1);
        end else begin
            expOp = op;
            expRd = rd;
            expRs = rs;
            expStarts++;
            checkVal("start_pulse", alu_start, 1);
            checkVal("start_op", {alu_op, alu_rd, alu_rs}, {expOp, expRd, expRs});
            checkVal("start_ready", in_ready, 0);
            // A done during the START cycle must be ignored.
            alu_done = 1'($urandom_range(0, 1));
            step();
            for (int k = 0; k < TIMEOUT && !gotDone; k++) begin
                alu_done = (k == delay);
                checkVal("wait_nostart", alu_start, 0);
                checkVal("wait_nowb", wb_en, 0);
                checkVal("wait_ready", in_ready, 0);
                checkVal("wait_op", alu_op, expOp);
                step();
                if (k == delay) gotDone = 1;
            end
            alu_done = 1'b0;
            if (gotDone) begin
                expWbs++;
                checkVal("wb_en", wb_en, 1);
                checkVal("wb_addr", wb_addr, expRd);
                checkVal("wb_ready", in_ready, 0);
                step();
                expRetired = expRetired + 1'b1;
                checkVal("post_wb_en", wb_en, 0);
                checkVal("post_wb_ready", in_ready, 1);
            end else begin
                expTimeout = 1'b1;
                checkVal("tmo_flag", timeout_err, 1);
                checkVal("tmo_nowb", wb_en, 0);
                checkVal("tmo_ready", in_ready, 1);
            end
        end
        checkVal("retired", retired, expRetired);
        checkVal("illegal_sticky", illegal, expIllegal);
        checkVal("tmo_sticky", timeout_err, expTimeout);
        checkVal("not_halted", halted, 0);
    endtask

    // Back-to-back doNothing words with in_valid held high.
    task automatic nopBurst(input int n);
        in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_instr = {4'h0, 5'($urandom)};
            checkVal("burst_ready", in_ready, 1);
            step();
            expRetired = expRetired + 1'b1;
            checkVal("burst_retired", retired, expRetired);
            checkVal("burst_nostart", alu_start, 0);
            checkVal("burst_nowb", wb_en, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic applyReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkResetOutputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkResetOutputs("rel");
    endtask

    initial begin
        logic [3:0] op;
        int         delay;

        // Initial reset
        #1;
        checkResetOutputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        checkResetOutputs("por_rel");

        // Directed scenarios
        sendInstr(4'h1, 3'd5, 2'd2, 0);
        nopBurst(3);
        sendInstr(4'h5, 3'd3, 2'd1, 10);
        sendInstr(4'hD, 3'd6, 2'd3, NEVER);
        sendInstr(4'h3, 3'd1, 2'd0, 2);
        sendInstr(4'hF, 3'd0, 2'd0, 0);
        sendInstr(4'h2, 3'd7, 2'd2, 1);
        sendInstr(4'h0, 3'd2, 2'd1, 0);

        // Randomized traffic (HALT excluded here; counter wraps at 2^CNT_W)
        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                in_instr = 9'($urandom);
                step();
            end
            op = 4'($urandom_range(0, 15));
            if (op == 4'hE) op = 4'h0;
            case ($urandom_range(0, 9))
                7, 8:    delay = $urandom_range(4, 12);
                9:       delay = NEVER;
                default: delay = $urandom_range(0, 3);
            endcase
            if ($urandom_range(0, 7) == 0) nopBurst($urandom_range(2, 5));
            sendInstr(op, 3'($urandom), 2'($urandom), delay);
        end
        checkVal("start_count", seenStarts, expStarts);
        checkVal("wb_count", seenWbs, expWbs);

        // HALT: everything afterwards ignored
        in_valid = 1'b1;
        in_instr = {4'hE, 5'($urandom)};
        step();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_instr = {4'h1, 5'($urandom)};
            alu_done = 1'($urandom_range(0, 1));
            checkVal("halt_flag", halted, 1);
            checkVal("halt_ready", in_ready, 0);
            checkVal("halt_nostart", alu_start, 0);
            checkVal("halt_nowb", wb_en, 0);
            checkVal("halt_retired", retired, expRetired);
            step();
        end
        in_valid = 1'b0;
        alu_done = 1'b0;
        applyReset();

        // Reset in the middle of WAIT aborts the op without writeback
        in_valid = 1'b1;
        in_instr = {4'h3, 3'd4, 2'd1};
        step();
        in_valid = 1'b0;
        expStarts++;
        checkVal("abort_start", alu_start, 1);
        step();
        step();
        alu_done = 1'b1;
        applyReset();
        for (int i = 0; i < 4; i++) begin
            checkVal("abort_nowb", wb_en, 0);
            checkVal("abort_nostart", alu_start, 0);
            checkVal("abort_retired", retired, 0);
            step();
        end
        alu_done = 1'b0;
        sendInstr(4'h4, 3'd2, 2'd3, 1);
        checkVal("final_start_count", seenStarts, expStarts);
        checkVal("final_wb_count", seenWbs, expWbs);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
